// File: rtl/trng_collector.sv
// TRNG collector: synchronizes a raw entropy bit, von Neumann debiases it,
// packs bytes for a valid/ready consumer and monitors repetition health.
module trng_collector #(
  parameter int XCLK_DIV  = 8,
  parameter int REP_LIMIT = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       raw_in,
  input  logic       enable,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       health_fail,
  output logic       overflow
);

  localparam int DW = (XCLK_DIV > 1) ? $clog2(XCLK_DIV) : 1;

  typedef enum logic {
    FIRST,
    SECOND
  } vn_t;

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] div;
  logic          strobe;

  vn_t           state;
  vn_t           state_nx;
  logic          first_bit;
  logic          first_nx;
  logic          emit;

  logic [7:0]    sr;
  logic [3:0]    cnt;
  logic          full_word;
  logic          load;

  logic [7:0]    run;
  logic          last_smp;

  assign strobe    = enable && (div == DW'(XCLK_DIV - 1));
  assign full_word = (cnt == 4'd8);
  assign load      = full_word && (!out_valid || out_ready)
                     && !health_fail;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      div   <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      if (!enable || strobe) div <= '0;
      else                   div <= div + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    first_nx = first_bit;
    emit     = 1'b0;
    if (!enable) begin
      state_nx = FIRST;
    end else if (strobe) begin
      case (state)
        FIRST: begin
          first_nx = sync2;
          state_nx = SECOND;
        end
        SECOND: begin
          emit     = (first_bit != sync2);
          state_nx = FIRST;
        end
        default: state_nx = FIRST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= FIRST;
      first_bit <= 1'b0;
    end else begin
      state     <= state_nx;
      first_bit <= first_nx;
    end
  end

  // A bit arriving during a word move starts the next word.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sr       <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (1'b1)
        load: begin
          out_data  <= sr;
          out_valid <= 1'b1;
          cnt       <= emit ? 4'd1 : 4'd0;
          if (emit) sr <= {sr[6:0], first_bit};
        end
        (emit && !full_word): begin
          sr  <= {sr[6:0], first_bit};
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
      if (!load && out_valid && out_ready) out_valid <= 1'b0;
      if (emit && full_word && !load) overflow <= 1'b1;
    end
  end

  // run==0 means no sample seen since reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      run         <= '0;
      last_smp    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (strobe) begin
        last_smp <= sync2;
        if (run != 8'd0 && sync2 == last_smp) begin
          if (run != 8'(REP_LIMIT)) run <= run + 8'd1;
        end else begin
          run <= 8'd1;
        end
      end
      if (run == 8'(REP_LIMIT)) health_fail <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// Bench for trng_collector: directed scenarios plus random raw streams
// checked against a pair/byte level reference model.
`timescale 1ns/1ps
module tb_trng_collector;

  localparam int DIV = 8;
  localparam int LIM = 32;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       raw_in = 1'b0;
  logic       enable = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       health_fail;
  logic       overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int first_valid = -1;
  bit rnd_ready = 1'b0;
  int low_run = 0;
  bit saw_valid = 1'b0;
  bit hold_chk = 1'b0;
  logic [7:0] hold_val;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit part_q[$];
  bit stim[$];
  int gen_run = 0;
  bit gen_last = 1'b0;

  trng_collector #(.XCLK_DIV(DIV), .REP_LIMIT(LIM)) dut (
    .clk(clk),
    .resetn(resetn),
    .raw_in(raw_in),
    .enable(enable),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .health_fail(health_fail),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (rnd_ready) begin
      if (low_run >= 12) out_ready = 1'b1;
      else out_ready = ($urandom_range(0, 3) != 0);
      low_run = out_ready ? 0 : low_run + 1;
    end
    if (hold_chk) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(hold_val));
    end
    hold_chk = out_valid && !out_ready && resetn;
    hold_val = out_data;
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (out_valid) saw_valid = 1'b1;
    if (out_valid && first_valid < 0) first_valid = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: non-overlapping pairs, differing pair emits its first
  // bit, eight emitted bits form a byte with the first bit as MSB.
  task automatic model_seg(input bit bits[$]);
    logic [7:0] w;
    for (int i = 0; i + 1 < bits.size(); i += 2) begin
      if (bits[i] != bits[i+1]) begin
        part_q.push_back(bits[i]);
        if (part_q.size() == 8) begin
          w = '0;
          foreach (part_q[j]) w[7-j] = part_q[j];
          exp_q.push_back(w);
          part_q.delete();
        end
      end
    end
  endtask

  task automatic seg(input bit bits[$]);
    enable = 1'b1;
    foreach (bits[k]) begin
      raw_in = bits[k];
      repeat (DIV) tick();
    end
    enable = 1'b0;
    model_seg(bits);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    enable = 1'b0;
    out_ready = 1'b0;
    rnd_ready = 1'b0;
    repeat (3) begin
      raw_in = ~raw_in;
      tick();
    end
    resetn = 1'b1;
    tick();
    got_q.delete();
    exp_q.delete();
    part_q.delete();
    gen_run = 0;
    saw_valid = 1'b0;
    hold_chk = 1'b0;
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic add_pairs(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      stim.push_back(b);
      stim.push_back(!b);
    end
  endtask

  task automatic add_rand(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      if (gen_run >= 20 && b == gen_last) b = !gen_last;
      gen_run = (gen_run > 0 && b == gen_last) ? gen_run + 1 : 1;
      gen_last = b;
      stim.push_back(b);
    end
  endtask

  initial begin
    // Reset with raw_in toggling.
    resetn = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      raw_in = ~raw_in;
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'h00);
      chk("rst_health", 32'(health_fail), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
    end
    do_reset();

    // Alternating pairs give 0x55 about 128 cycles after enable.
    out_ready = 1'b1;
    stim.delete();
    for (int i = 0; i < 4; i++) begin
      stim.push_back(1'b0); stim.push_back(1'b1);
      stim.push_back(1'b1); stim.push_back(1'b0);
    end
    cyc = 0;
    first_valid = -1;
    seg(stim);
    repeat (4) tick();
    chk("p55_rise", 32'(first_valid >= 128 && first_valid <= 130), 32'd1);
    cmp_stream("p55");
    if (got_q.size() > 0) chk("p55_val", 32'(got_q[0]), 32'h55);
    chk("p55_ovf", 32'(overflow), 32'd0);

    // Equal pairs discarded; only (1,0) pairs count.
    do_reset();
    out_ready = 1'b1;
    stim.delete();
    for (int i = 0; i < 8; i++) begin
      stim.push_back(1'b1); stim.push_back(1'b1);
      stim.push_back(1'b0); stim.push_back(1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      stim.push_back(1'b1); stim.push_back(1'b0);
    end
    seg(stim);
    repeat (4) tick();
    cmp_stream("pff");
    if (got_q.size() > 0) chk("pff_val", 32'(got_q[0]), 32'hff);

    // Repetition: 31 ones then a zero must not fail.
    do_reset();
    out_ready = 1'b1;
    stim.delete();
    repeat (31) stim.push_back(1'b1);
    stim.push_back(1'b0);
    seg(stim);
    repeat (3) tick();
    chk("rep31", 32'(health_fail), 32'd0);

    // 32 ones fail, and the flag blocks new words.
    do_reset();
    out_ready = 1'b1;
    stim.delete();
    repeat (31) stim.push_back(1'b1);
    seg(stim);
    repeat (3) tick();
    chk("rep31b", 32'(health_fail), 32'd0);
    stim.delete();
    stim.push_back(1'b1);
    seg(stim);
    repeat (2) tick();
    chk("rep32", 32'(health_fail), 32'd1);
    saw_valid = 1'b0;
    stim.delete();
    for (int i = 0; i < 16; i++) begin
      stim.push_back(1'b0); stim.push_back(1'b1);
    end
    seg(stim);
    repeat (4) tick();
    chk("hf_noword", 32'(saw_valid), 32'd0);
    chk("hf_sticky", 32'(health_fail), 32'd1);

    // Backpressure: 17 emitted bits, last one overflows.
    do_reset();
    out_ready = 1'b0;
    stim.delete();
    add_pairs(16);
    seg(stim);
    repeat (3) tick();
    chk("bp_ovf0", 32'(overflow), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    if (exp_q.size() > 0) chk("bp_data", 32'(out_data), 32'(exp_q[0]));
    stim.delete();
    add_pairs(1);
    seg(stim);
    repeat (2) tick();
    chk("bp_ovf1", 32'(overflow), 32'd1);
    if (exp_q.size() > 0) chk("bp_data2", 32'(out_data), 32'(exp_q[0]));
    out_ready = 1'b1;
    tick();
    chk("coin_valid", 32'(out_valid), 32'd1);
    if (exp_q.size() > 1) chk("coin_data", 32'(out_data), 32'(exp_q[1]));
    tick();
    chk("coin_fall", 32'(out_valid), 32'd0);
    cmp_stream("bp");

    // Reset mid-operation discards held and partial words.
    do_reset();
    out_ready = 1'b0;
    stim.delete();
    add_pairs(19);
    seg(stim);
    repeat (2) tick();
    do_reset();
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_data", 32'(out_data), 32'h00);
    chk("mid_ovf", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    stim.delete();
    add_pairs(8);
    seg(stim);
    repeat (4) tick();
    cmp_stream("mid");

    // Random streams, ragged enable segments, random backpressure.
    do_reset();
    rnd_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      stim.delete();
      add_rand($urandom_range(9, 70));
      seg(stim);
      repeat ($urandom_range(1, 5)) tick();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    cmp_stream("rnd");
    chk("rnd_ovf", 32'(overflow), 32'd0);
    chk("rnd_health", 32'(health_fail), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
